// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter slice.
//   ADDR_W / DATA_W : default word-address and data widths
//   NUM_REQ         : number of requesters (0 = core, 1 = loader)
//   req_id_t        : requester index type
//   arb_state_t     : arbiter FSM states (free, or locked to one requester)
//   id_to_onehot    : converts a requester index into a one-hot vector
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int NUM_REQ = 2;

    typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;

    typedef enum logic [1:0] {
        ARB_FREE  = 2'd0,
        ARB_LOCK0 = 2'd1,
        ARB_LOCK1 = 2'd2
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] id_to_onehot(input req_id_t id);
        return (id == 1'b1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Two-way round-robin tie-break used while the bus is not locked.
//   req     (in)  : request vector, bit 0 = core, bit 1 = loader
//   rr_last (in)  : id of the requester that made the most recent transfer
//   pick    (out) : one-hot winner, or zero when nobody requests
// ---------------------------------------------------------------------------
module rr_arbiter
    import dmem_arb_pkg::*;
(
    input  logic       [1:0] req,
    input  logic             rr_last,
    output logic       [1:0] pick
);

    // A lone request always wins; on a tie the requester that did not
    // transfer last time gets the bus.
    always_comb begin
        pick = 2'b00;
        unique case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = id_to_onehot(~rr_last);
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port data memory between the core (requester 0) and
// the loader (requester 1). Grants are combinational; a requester may hold
// the bus across transfers with its lock bit. Reads return one cycle later.
//   clk, rst          : clock, asynchronous active-low reset
//   req, lock         : per-requester request and bus-hold request
//   we, addr, wdata   : per-requester byte strobes (0000 = read), word
//                       address and write data, requester 1 in upper half
//   gnt               : one-hot grant; transfer when req[i] & gnt[i]
//   rvalid, rdata     : registered read response, rdata zero when idle
//   m_we, m_addr,
//   m_wdata, m_rdata  : memory port
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W = dmem_arb_pkg::ADDR_W,
    parameter int DATA_W = dmem_arb_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  logic [1:0]            lock,
    input  logic [7:0]            we,
    input  logic [2*ADDR_W-1:0]   addr,
    input  logic [2*DATA_W-1:0]   wdata,
    output logic [1:0]            gnt,
    output logic [1:0]            rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic [3:0]            m_we,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic [DATA_W-1:0]     m_rdata
);

    import dmem_arb_pkg::arb_state_t;
    import dmem_arb_pkg::ARB_FREE;
    import dmem_arb_pkg::ARB_LOCK0;
    import dmem_arb_pkg::ARB_LOCK1;
    import dmem_arb_pkg::req_id_t;
    import dmem_arb_pkg::id_to_onehot;

    arb_state_t state_q;
    req_id_t    rr_last_q;
    logic [1:0] rvalid_q;

    logic [1:0] pick;
    logic [1:0] gnt_d;
    logic [1:0] xfer;
    logic       xfer_any;
    req_id_t    xfer_id;

    rr_arbiter u_rr (
        .req     (req),
        .rr_last (rr_last_q),
        .pick    (pick)
    );

    // Grant depends only on req and registered state, never on m_rdata.
    // While locked, the owner is granted whenever it asks and the other
    // requester is shut out. Reset forces the grant low.
    always_comb begin
        gnt_d = 2'b00;
        unique case (state_q)
            ARB_FREE:  gnt_d = pick;
            ARB_LOCK0: gnt_d = {1'b0, req[0]};
            ARB_LOCK1: gnt_d = {req[1], 1'b0};
            default:   gnt_d = 2'b00;
        endcase
        if (!rst) begin
            gnt_d = 2'b00;
        end
    end

    assign gnt      = gnt_d;
    assign xfer     = req & gnt_d;
    assign xfer_any = |xfer;
    assign xfer_id  = xfer[1];

    // Memory port carries the winner's request, and is quiet otherwise.
    always_comb begin
        m_we    = 4'b0000;
        m_addr  = '0;
        m_wdata = '0;
        if (xfer_any) begin
            if (xfer_id == 1'b1) begin
                m_we    = we[7:4];
                m_addr  = addr[2*ADDR_W-1:ADDR_W];
                m_wdata = wdata[2*DATA_W-1:DATA_W];
            end else begin
                m_we    = we[3:0];
                m_addr  = addr[ADDR_W-1:0];
                m_wdata = wdata[DATA_W-1:0];
            end
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = (|rvalid_q) ? m_rdata : '0;

    // Arbiter FSM. A lock is taken by transferring with lock set and held
    // until the owner drops its lock bit; the transfer in that same cycle
    // is still granted because the state only changes on the next edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ARB_FREE;
            rr_last_q <= 1'b1;
            rvalid_q  <= 2'b00;
        end else begin
            rvalid_q <= 2'b00;
            if (xfer_any) begin
                rr_last_q <= xfer_id;
                if (m_we == 4'b0000) begin
                    rvalid_q <= id_to_onehot(xfer_id);
                end
            end
            unique case (state_q)
                ARB_FREE: begin
                    if (xfer_any && lock[xfer_id]) begin
                        state_q <= (xfer_id == 1'b1) ? ARB_LOCK1 : ARB_LOCK0;
                    end
                end
                ARB_LOCK0: begin
                    if (!lock[0]) begin
                        state_q <= ARB_FREE;
                    end
                end
                ARB_LOCK1: begin
                    if (!lock[1]) begin
                        state_q <= ARB_FREE;
                    end
                end
                default: state_q <= ARB_FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Scoreboard bench for dmem_arbiter. The driver applies one cycle of
// stimulus per falling edge, evaluates a behavioural model of the arbiter
// (lock owner, last winner, list of outstanding reads) and queues what the
// DUT must show this cycle plus any read response due later. A separate
// monitor pops those expectations shortly after each falling edge.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          req;
    logic [1:0]          lock;
    logic [7:0]          we;
    logic [2*ADDR_W-1:0] addr;
    logic [2*DATA_W-1:0] wdata;
    logic [1:0]          gnt;
    logic [1:0]          rvalid;
    logic [DATA_W-1:0]   rdata;
    logic [3:0]          m_we;
    logic [ADDR_W-1:0]   m_addr;
    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W-1:0]   m_rdata;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .lock    (lock),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .gnt     (gnt),
        .rvalid  (rvalid),
        .rdata   (rdata),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [1:0]  gnt;
        logic [3:0]  mwe;
        logic [31:0] maddr;
        logic [31:0] mwdata;
    } cycExp_t;

    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } resp_t;

    cycExp_t expQ[$];
    resp_t   respQ[$];

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference model state: who holds the lock (-1 = nobody) and who
    // transferred most recently.
    int          lockOwner  = -1;
    int          lastWinner = 1;
    logic [31:0] rdataPlan;
    bit          overrideValid = 1'b0;
    logic [31:0] overrideData;

    // Compare one observed value against its expectation and count it.
    task automatic checkOutput(input string name, input int cyc,
                               input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, actual, expected);
        end
    endtask

    // Drive one cycle and record what the model predicts for it.
    task automatic applyStimulus(input logic rstV, input logic [1:0] reqV,
                                 input logic [1:0] lockV, input logic [7:0] weV,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] d0, input logic [31:0] d1);
        cycExp_t    e;
        resp_t      r;
        int         id;
        logic [1:0] g;
        @(negedge clk);
        cycle++;
        rst     = rstV;
        req     = reqV;
        lock    = lockV;
        we      = weV;
        addr    = {a1, a0};
        wdata   = {d1, d0};
        m_rdata = rdataPlan;
        rdataPlan     = overrideValid ? overrideData : $urandom;
        overrideValid = 1'b0;

        e.cyc = cycle; e.gnt = 2'b00; e.mwe = 4'b0000; e.maddr = '0; e.mwdata = '0;
        id = 0;
        if (!rstV) begin
            respQ.delete();
            lockOwner  = -1;
            lastWinner = 1;
        end else begin
            if (lockOwner >= 0)
                g = reqV[lockOwner] ? (2'b01 << lockOwner) : 2'b00;
            else if (reqV == 2'b11)
                g = 2'b01 << (1 - lastWinner);
            else
                g = reqV;
            e.gnt = g;
            if (g != 2'b00) begin
                id       = g[1] ? 1 : 0;
                e.mwe    = (id == 1) ? weV[7:4] : weV[3:0];
                e.maddr  = (id == 1) ? a1 : a0;
                e.mwdata = (id == 1) ? d1 : d0;
                lastWinner = id;
                if (e.mwe == 4'b0000) begin
                    r.due = cycle + 1; r.id = id; r.data = rdataPlan;
                    respQ.push_back(r);
                end
            end
            if (lockOwner >= 0) begin
                if (!lockV[lockOwner]) lockOwner = -1;
            end else if (g != 2'b00 && lockV[id]) begin
                lockOwner = id;
            end
        end
        expQ.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 2'b00, 2'b00, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic resetCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, 2'b00, 8'h00, 0, 0, 0, 0);
    endtask

    // Monitor: pop this cycle's expectations and any response that is due.
    initial begin : monitor
        cycExp_t     e;
        logic [1:0]  expRv;
        logic [31:0] expRd;
        forever begin
            @(negedge clk);
            #2;
            while (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("gnt",     e.cyc, {62'd0, gnt},     {62'd0, e.gnt});
                checkOutput("m_we",    e.cyc, {60'd0, m_we},    {60'd0, e.mwe});
                checkOutput("m_addr",  e.cyc, {32'd0, m_addr},  {32'd0, e.maddr});
                checkOutput("m_wdata", e.cyc, {32'd0, m_wdata}, {32'd0, e.mwdata});
                expRv = 2'b00;
                expRd = '0;
                if (respQ.size() > 0 && respQ[0].due == e.cyc) begin
                    expRv = (respQ[0].id == 1) ? 2'b10 : 2'b01;
                    expRd = respQ[0].data;
                    void'(respQ.pop_front());
                end
                checkOutput("rvalid", e.cyc, {62'd0, rvalid}, {62'd0, expRv});
                checkOutput("rdata",  e.cyc, {32'd0, rdata},  {32'd0, expRd});
            end
        end
    end

    initial begin : driver
        logic        rstV;
        logic [1:0]  reqV;
        logic [1:0]  lockV;
        logic [7:0]  weV;
        rst = 1'b0; req = '0; lock = '0; we = '0; addr = '0; wdata = '0; m_rdata = '0;
        rdataPlan = $urandom;

        resetCycles(3);

        // Single core read at 0x10, memory answers DEADBEEF next cycle.
        overrideValid = 1'b1; overrideData = 32'hDEADBEEF;
        applyStimulus(1'b1, 2'b01, 2'b00, 8'h00, 32'h10, 0, 0, 0);
        idle(1);

        // Fresh reset, then both requesters held: grants alternate 0,1,0,1.
        resetCycles(1);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 2'b11, 2'b00, 8'h00, 32'h100 + i, 32'h200 + i, 0, 0);
        idle(1);

        // Loader locks for three writes while the core keeps asking; the
        // third write happens as the lock drops, then the core gets in.
        applyStimulus(1'b1, 2'b01, 2'b00, 8'h0F, 32'h4, 0, 32'h1, 0);
        applyStimulus(1'b1, 2'b11, 2'b10, 8'hFF, 32'h5, 32'h40, 32'h2, 32'hA0);
        applyStimulus(1'b1, 2'b11, 2'b10, 8'hFF, 32'h6, 32'h41, 32'h3, 32'hA1);
        applyStimulus(1'b1, 2'b11, 2'b00, 8'hFF, 32'h7, 32'h42, 32'h4, 32'hA2);
        applyStimulus(1'b1, 2'b11, 2'b00, 8'hF0, 32'h8, 32'h43, 32'h5, 32'hA3);
        idle(1);

        // Core read followed directly by a loader write.
        applyStimulus(1'b1, 2'b01, 2'b00, 8'h00, 32'h20, 0, 0, 0);
        applyStimulus(1'b1, 2'b10, 2'b00, 8'hF0, 0, 32'h21, 0, 32'hCAFEF00D);
        idle(2);

        // Reset while the core holds a lock with a read in flight.
        applyStimulus(1'b1, 2'b01, 2'b01, 8'h00, 32'h30, 0, 0, 0);
        applyStimulus(1'b1, 2'b01, 2'b01, 8'h00, 32'h31, 0, 0, 0);
        applyStimulus(1'b0, 2'b11, 2'b01, 8'h00, 32'h32, 32'h33, 0, 0);
        applyStimulus(1'b0, 2'b11, 2'b01, 8'h00, 32'h32, 32'h33, 0, 0);
        applyStimulus(1'b1, 2'b10, 2'b00, 8'hF0, 0, 32'h34, 0, 32'h55);
        idle(1);

        // Partial write of the low half-word.
        applyStimulus(1'b1, 2'b01, 2'b00, 8'h03, 32'h3, 0, 32'h12345678, 0);
        idle(2);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rstV  = ($urandom_range(0, 59) != 0);
            reqV  = 2'($urandom);
            lockV = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            weV[3:0] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            weV[7:4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            applyStimulus(rstV, reqV, lockV, weV, $urandom, $urandom, $urandom, $urandom);
        end
        idle(3);

        @(negedge clk);
        #4;
        checkOutput("drain", cycle, 64'(respQ.size() + expQ.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the data width.
REQ-003 The block SHALL have port clk  input  1  as its single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst  input  1  as the reset: asynchronous, active-low.
REQ-005 The block SHALL have port req  input  2  as the per-requester transfer request; bit 0 is the core, bit 1 is the loader.
REQ-006 The block SHALL have port lock  input  2  to request that the bus be held after the current transfer.
REQ-007 The block SHALL have port we  input  2x4  as the per-requester byte write strobes; 4'b0000 marks a read.
REQ-008 The block SHALL have port addr  input  2xADDR_W  as the per-requester word address.
REQ-009 The block SHALL have port wdata  input  2xDATA_W  as the per-requester write data.
REQ-010 The block SHALL have port gnt  output  2  as the grant; a transfer occurs in any cycle where req[i] and gnt[i] are both 1.
REQ-011 The block SHALL have port rvalid  output  2  to mark a valid read response for requester i.
REQ-012 The block SHALL have port rdata  output  DATA_W  as the read data, shared by both requesters and qualified by rvalid.
REQ-013 The block SHALL have port m_we  output  4  as the memory byte write strobes.
REQ-014 The block SHALL have ports m_addr  output  ADDR_W  and m_wdata  output  DATA_W  as the memory address and write data.
REQ-015 The block SHALL have port m_rdata  input  DATA_W  as memory read data, valid one cycle after the address is presented.

Function
REQ-016 gnt SHALL be combinational from req and the current state, and SHALL be one-hot or zero.
REQ-017 The FSM SHALL have states ARB_FREE, ARB_LOCK0 and ARB_LOCK1.
REQ-018 In ARB_FREE, a single request SHALL be granted in the same cycle.
REQ-019 In ARB_FREE with both requests, the grant SHALL go to the requester not recorded in rr_last.
REQ-020 rr_last SHALL update to the granted id on every transfer.
REQ-021 A transfer by requester i with lock[i]=1 SHALL move the FSM to ARB_LOCKi on the next edge.
REQ-022 In ARB_LOCKi, gnt SHALL equal req[i] for the owner, and gnt for the other requester SHALL be 0.
REQ-023 In ARB_LOCKi, a cycle with lock[i]=0 SHALL return the FSM to ARB_FREE on the next edge.
REQ-024 A transfer in the same cycle that lock[i] drops SHALL still be granted.
REQ-025 On a transfer, m_addr, m_wdata and m_we SHALL equal the granted requester's addr, wdata and we.
REQ-026 With no transfer, m_we SHALL be 4'b0000, m_addr 0 and m_wdata 0.
REQ-027 A read transfer by requester i in cycle N SHALL assert rvalid[i] only in cycle N+1, with rdata=m_rdata.
REQ-028 rvalid SHALL be registered and one-hot or zero; rdata SHALL be 0 when rvalid is 0.
REQ-029 Write transfers SHALL produce no rvalid.
REQ-030 Back-to-back reads SHALL sustain one transfer per cycle, with the responses in issue order.

Reset
REQ-031 While rst=0, the block SHALL hold state ARB_FREE, rr_last=1 (requester 0 wins the first tie) and rvalid=0.
REQ-032 While rst=0, gnt and m_we SHALL be forced to 0.
REQ-033 Reset asserted mid-operation SHALL drop any pending read response and release any lock immediately.
REQ-034 The first grant after rst rises SHALL follow REQ-018/019 using the reset value of rr_last.

Structure
REQ-035 A shared package dmem_arb_pkg SHALL hold ADDR_W, DATA_W, NUM_REQ=2, typedef req_id_t and enum arb_state_t.
REQ-036 The tie-break SHALL live in a sub-module rr_arbiter: inputs req[1:0] and rr_last, output a one-hot pick.
REQ-037 The block SHALL contain no combinational path from m_rdata to gnt.

Verification
REQ-038 Only req[0], read at addr 0x10, with m_rdata=0xDEADBEEF next cycle -> gnt=01 in the same cycle, then rvalid=01 and rdata=0xDEADBEEF.
REQ-039 Both requests held, no lock, after reset -> the grant sequence is 0,1,0,1 with one transfer per cycle.
REQ-040 Requester 1 with lock=1 for 3 writes, we=1111, while req[0]=1 -> gnt=10 for 3 cycles, gnt[0]=0, then gnt[0]=1 on the cycle after lock[1] drops.
REQ-041 A read by requester 0 in cycle N, then a write by requester 1 in N+1 -> rvalid=01 in N+1, m_we=1111 in N+1, no rvalid in N+2.
REQ-042 rst driven low in the cycle after a read transfer while in ARB_LOCK0 -> rvalid stays 0, the state is ARB_FREE and gnt=00 throughout reset.
REQ-043 Partial write with we=0011 and wdata=0x12345678 at addr 0x3 -> m_we=0011, m_addr=0x3, m_wdata=0x12345678 for exactly one cycle.
